// File: rtl/pd_block_led_pwm_pkg.sv
// rtl/pd_block_led_pwm_pkg.sv - register offsets and shared types for the LED PWM port
package pd_block_led_pwm_pkg;

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_MODE     = 3'd1,
        REG_PRESCALE = 3'd2,
        REG_DUTY     = 3'd3,
        REG_OUTSET   = 3'd4,
        REG_OUTCLR   = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_addr_e;

    localparam logic [2:0] ADDR_DATA     = REG_DATA;
    localparam logic [2:0] ADDR_MODE     = REG_MODE;
    localparam logic [2:0] ADDR_PRESCALE = REG_PRESCALE;
    localparam logic [2:0] ADDR_DUTY     = REG_DUTY;
    localparam logic [2:0] ADDR_OUTSET   = REG_OUTSET;
    localparam logic [2:0] ADDR_OUTCLR   = REG_OUTCLR;

    localparam int RESET_MODE     = 0;
    localparam int RESET_PRESCALE = 0;
    localparam int RESET_DUTY     = 0;

endpackage

// File: rtl/pd_block_led_pwm_if.sv
// rtl/pd_block_led_pwm_if.sv - Avalon-MM style register bus for the LED PWM port
interface pd_block_led_pwm_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pd_block_led_pwm_gen.sv
// rtl/pd_block_led_pwm_gen.sv - prescaler, PWM phase counter and duty compare
module pd_block_led_pwm_gen #(
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic                     prescale_wr,
  input  logic [PWM_BITS:0]        duty,
  output logic                     pwm_on
);
  logic [PRESCALE_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0]      r_phase;
  logic                     w_tick;
  logic [PWM_BITS-1:0]      w_phase_next;

  // A PRESCALE write restarts the count and suppresses the tick in that cycle.
  assign w_tick       = !prescale_wr && (r_cnt >= prescale);
  assign w_phase_next = r_phase + PWM_BITS'(w_tick);
  // pwm_on reflects the phase after this edge so the output register lines up with it.
  assign pwm_on       = ({1'b0, w_phase_next} < duty);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else begin
      if (prescale_wr || w_tick) r_cnt <= '0;
      else                       r_cnt <= r_cnt + 1'b1;
      r_phase <= w_phase_next;
    end
  end
endmodule

// File: rtl/pd_block_led_pwm.sv
// rtl/pd_block_led_pwm.sv - LED output port with per-channel PWM dimming and set/clear writes
module pd_block_led_pwm
  import pd_block_led_pwm_pkg::*;
#(
  parameter int               WIDTH         = 10,
  parameter int               PWM_BITS      = 8,
  parameter int               PRESCALE_BITS = 16,
  parameter logic [WIDTH-1:0] RESET_DATA    = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  pd_block_led_pwm_if.slave   bus,
  output logic [WIDTH-1:0]    out_port
);
  logic [WIDTH-1:0]         r_data;
  logic [WIDTH-1:0]         r_mode;
  logic [PRESCALE_BITS-1:0] r_prescale;
  logic [PWM_BITS:0]        r_duty;

  logic                     w_wr;
  reg_addr_e                w_addr;
  logic [WIDTH-1:0]         w_wd;
  logic [WIDTH-1:0]         w_data_next;
  logic [WIDTH-1:0]         w_mode_next;
  logic [PWM_BITS:0]        w_duty_next;
  logic                     w_prescale_wr;
  logic                     w_pwm_on;

  assign w_wr          = bus.chipselect && !bus.write_n;
  assign w_addr        = reg_addr_e'(bus.address);
  assign w_wd          = bus.writedata[WIDTH-1:0];
  assign w_prescale_wr = w_wr && (w_addr == REG_PRESCALE);

  always_comb begin
    w_data_next = r_data;
    w_mode_next = r_mode;
    w_duty_next = r_duty;
    if (w_wr) begin
      case (w_addr)
        REG_DATA:   w_data_next = w_wd;
        REG_MODE:   w_mode_next = w_wd;
        REG_DUTY:   w_duty_next = bus.writedata[PWM_BITS:0];
        REG_OUTSET: w_data_next = r_data | w_wd;
        REG_OUTCLR: w_data_next = r_data & ~w_wd;
        default:    ;
      endcase
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (w_addr)
      REG_DATA:     bus.readdata = 32'(r_data);
      REG_MODE:     bus.readdata = 32'(r_mode);
      REG_PRESCALE: bus.readdata = 32'(r_prescale);
      REG_DUTY:     bus.readdata = 32'(r_duty);
      default:      bus.readdata = '0;
    endcase
  end

  pd_block_led_pwm_gen #(
    .PWM_BITS      (PWM_BITS),
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .prescale    (r_prescale),
    .prescale_wr (w_prescale_wr),
    .duty        (w_duty_next),
    .pwm_on      (w_pwm_on)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_DATA;
      r_mode     <= WIDTH'(RESET_MODE);
      r_prescale <= PRESCALE_BITS'(RESET_PRESCALE);
      r_duty     <= (PWM_BITS+1)'(RESET_DUTY);
      out_port   <= RESET_DATA;
    end else begin
      r_data   <= w_data_next;
      r_mode   <= w_mode_next;
      r_duty   <= w_duty_next;
      if (w_prescale_wr) r_prescale <= bus.writedata[PRESCALE_BITS-1:0];
      out_port <= w_data_next & (~w_mode_next | {WIDTH{w_pwm_on}});
    end
  end
endmodule

// File: tb/tb_pd_block_led_pwm.sv
// tb/tb_pd_block_led_pwm.sv - randomized self-checking bench for pd_block_led_pwm
module tb_pd_block_led_pwm;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] out_port;
  int         n_pass = 0;
  int         n_chk  = 0;

  pd_block_led_pwm_if bus ();

  pd_block_led_pwm #(.WIDTH(10), .PWM_BITS(8), .PRESCALE_BITS(16), .RESET_DATA(10'h000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  // Reference state: registers, clocks elapsed since last prescaler restart, ticks elapsed mod 256.
  int unsigned m_data, m_mode, m_pre, m_duty, m_cnt, m_phase, m_out;

  function automatic int unsigned m_read(input int unsigned a);
    case (a)
      0: return m_data;
      1: return m_mode;
      2: return m_pre;
      3: return m_duty;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = 0; m_mode = 0; m_pre = 0; m_duty = 0; m_cnt = 0; m_phase = 0; m_out = 0;
    end else begin
      automatic bit          wr  = bus.chipselect && !bus.write_n;
      automatic int unsigned a   = bus.address;
      automatic int unsigned wd  = bus.writedata;
      automatic bit          tick = 0;
      if (wr && a == 2) begin
        m_cnt = 0;
      end else if (m_cnt >= m_pre) begin
        m_cnt = 0;
        tick  = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (wr) begin
        case (a)
          0: m_data = wd % 1024;
          1: m_mode = wd % 1024;
          2: m_pre  = wd % 65536;
          3: m_duty = wd % 512;
          4: m_data = m_data | (wd % 1024);
          5: m_data = m_data & ~(wd % 1024) & 32'h3FF;
          default: ;
        endcase
      end
      if (tick) m_phase = (m_phase + 1) % 256;
      m_out = (m_phase < m_duty) ? m_data : (m_data & ~m_mode & 32'h3FF);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    check("out_port_model", {22'd0, out_port}, m_out);
    check("readdata_model", bus.readdata, m_read(bus.address));
  end

  task automatic idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 check(name, bus.readdata, exp);
    @(negedge clk);
    idle();
  endtask

  task automatic count_on(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_port[0]) ones++;
    end
  endtask

  initial begin
    int ones;
    bus.address = '0; bus.writedata = '0;
    idle();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rd("reset_data", 3'd0, 32'h0);
    rd("reset_mode", 3'd1, 32'h0);

    wr(3'd0, 32'h3FF); check("static_data", {22'd0, out_port}, 32'h3FF);
    wr(3'd5, 32'h00F); check("outclr", {22'd0, out_port}, 32'h3F0);
    wr(3'd4, 32'h001); check("outset", {22'd0, out_port}, 32'h3F1);
    rd("read_data", 3'd0, 32'h3F1);
    rd("read_outset", 3'd4, 32'h0);

    wr(3'd2, 32'd0); wr(3'd3, 32'd64); wr(3'd1, 32'h001); wr(3'd0, 32'h001);
    count_on(256, ones); check("duty64_ones", ones, 64);
    wr(3'd3, 32'd0);   count_on(256, ones); check("duty0_ones", ones, 0);
    wr(3'd3, 32'd256); count_on(256, ones); check("duty256_ones", ones, 256);
    wr(3'd3, 32'd128); count_on(256, ones); check("duty128_ones", ones, 128);
    wr(3'd3, 32'd64);  wr(3'd2, 32'd3);
    count_on(1024, ones); check("pre3_ones", ones, 256);
    wr(3'd2, 32'd9); repeat (7) @(negedge clk); wr(3'd2, 32'd2);
    repeat (20) @(negedge clk);

    wr(3'd0, 32'h155);
    wr(3'd6, 32'hFFFFFFFF); wr(3'd7, 32'hFFFFFFFF);
    @(negedge clk);
    bus.address = 3'd0; bus.writedata = 32'h2AA; bus.chipselect = 1'b0; bus.write_n = 1'b0;
    @(negedge clk); idle();
    rd("decode_noop", 3'd0, 32'h155);
    rd("rsvd6_read", 3'd6, 32'h0);
    wr(3'd0, 32'hFFFFFFFF);
    rd("data_trunc", 3'd0, 32'h3FF);
    wr(3'd3, 32'hFFFFFFFF);
    rd("duty_trunc", 3'd3, 32'h1FF);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        bus.address = 3'd0; idle();
        reset_n = 1'b0;
        #1 check("async_rst_out", {22'd0, out_port}, 32'h0);
        for (int a = 0; a < 8; a++) begin
          bus.address = 3'(a);
          #1 check("async_rst_read", bus.readdata, 32'h0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end else begin
        bus.address    = 3'($urandom_range(0, 7));
        bus.chipselect = ($urandom_range(0, 3) != 0);
        bus.write_n    = ($urandom_range(0, 2) == 0);
        case (bus.address)
          3'd2: bus.writedata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
          3'd3: bus.writedata = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300));
          default: bus.writedata = $urandom;
        endcase
        if (bus.address == 3'd2 && bus.writedata > 32'd5 && $urandom_range(0, 1) == 0)
          bus.writedata = 32'd1;
      end
    end
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
